// File: rtl/product_scatter_arbiter_pkg.sv
// rtl/product_scatter_arbiter_pkg.sv - shared sizes, types and address map for the product scatter arbiter
package product_scatter_arbiter_pkg;

    localparam int NUM_PROD        = 16;
    localparam int NUM_BANKS       = 32;
    localparam int BANK_W          = $clog2(NUM_BANKS);
    localparam int DATA_W          = 24;
    localparam int ADDR_W          = 10;
    localparam int MAX_SIZE_OUTPUT = 64;
    localparam int MAX_NUM_K       = 16;
    localparam int COORD_W         = $clog2(MAX_SIZE_OUTPUT) + 1;
    localparam int K_W             = $clog2(MAX_NUM_K) + 1;
    // Wide enough for k*side*side + (row-1)*side + col at the field maxima,
    // so the linear index never wraps before bank/address extraction.
    localparam int LIN_W           = K_W + 2 * COORD_W + 1;

    localparam logic [LIN_W-1:0] LIN_ONE = LIN_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } acc_wr_t;

    typedef struct packed {
        logic [BANK_W-1:0] bank;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } scatter_entry_t;

    // Row and column are 1-based; low bits of the linear index pick the bank.
    function automatic scatter_entry_t map_entry(
        input logic [K_W-1:0]     k,
        input logic [COORD_W-1:0] row,
        input logic [COORD_W-1:0] col,
        input logic [COORD_W-1:0] side,
        input logic [DATA_W-1:0]  data
    );
        logic [LIN_W-1:0] s;
        logic [LIN_W-1:0] lin;
        scatter_entry_t   e;
        s      = LIN_W'(side);
        lin    = LIN_W'(k) * s * s + (LIN_W'(row) - LIN_ONE) * s + LIN_W'(col) - LIN_ONE;
        e.bank = lin[BANK_W-1:0];
        e.addr = ADDR_W'(lin >> BANK_W);
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/product_scatter_arbiter_if.sv
// rtl/product_scatter_arbiter_if.sv - product group handshake between the coordinate stage and the arbiter
//   in_valid : per-product valid mask
//   in_row   : 1-based output row per product
//   in_col   : 1-based output column per product
//   in_k     : output channel per product
//   in_data  : product value per product
//   in_ready : group accepted when high together with |in_valid
interface product_scatter_arbiter_if;
    import product_scatter_arbiter_pkg::*;

    logic [NUM_PROD-1:0]              in_valid;
    logic [NUM_PROD-1:0][COORD_W-1:0] in_row;
    logic [NUM_PROD-1:0][COORD_W-1:0] in_col;
    logic [NUM_PROD-1:0][K_W-1:0]     in_k;
    logic [NUM_PROD-1:0][DATA_W-1:0]  in_data;
    logic                             in_ready;

    modport master (
        output in_valid, in_row, in_col, in_k, in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_row, in_col, in_k, in_data,
        output in_ready
    );
endinterface

// File: rtl/product_scatter_arbiter_bank_priority_grant.sv
// rtl/product_scatter_arbiter_bank_priority_grant.sv - lowest-index one-hot grant for one accumulator bank
//   pending : registered pending mask of the current group
//   bank    : bank number of each product
//   grant   : one-hot (or zero) grant for products mapped to BANK_ID
module bank_priority_grant
    import product_scatter_arbiter_pkg::*;
#(
    parameter int BANK_ID = 0
) (
    input  logic [NUM_PROD-1:0]             pending,
    input  logic [NUM_PROD-1:0][BANK_W-1:0] bank,
    output logic [NUM_PROD-1:0]             grant
);

    logic [NUM_PROD-1:0] req;

    always_comb begin
        req = '0;
        for (int p = 0; p < NUM_PROD; p++) begin
            req[p] = pending[p] && (bank[p] == BANK_W'(BANK_ID));
        end
    end

    // Isolate the lowest set bit: two's complement of req keeps only that bit in common.
    assign grant = req & (~req + NUM_PROD'(1));

endmodule

// File: rtl/product_scatter_arbiter.sv
// rtl/product_scatter_arbiter.sv - scatters product groups to accumulator banks, one write per bank per cycle
//   clk, rst        : clock (rising edge), asynchronous active-low reset
//   flush           : synchronous drop of all pending products
//   out_side_length : output tile side, static while busy
//   up              : product group handshake (slave side)
//   acc_stall       : accumulator back-pressure, freezes all state
//   acc_wr_*        : registered per-bank write strobe, address and data
//   busy            : a group is still being issued
//   conflict_cycles : saturating count of drain cycles
module product_scatter_arbiter
    import product_scatter_arbiter_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic [COORD_W-1:0]               out_side_length,
    product_scatter_arbiter_if.slave         up,
    input  logic                             acc_stall,
    output logic [NUM_BANKS-1:0]             acc_wr_en,
    output logic [NUM_BANKS-1:0][ADDR_W-1:0] acc_wr_addr,
    output logic [NUM_BANKS-1:0][DATA_W-1:0] acc_wr_data,
    output logic                             busy,
    output logic [15:0]                      conflict_cycles
);

    state_t                          state_q;
    state_t                          state_d;
    logic [NUM_PROD-1:0]             pend_q;
    logic [NUM_PROD-1:0]             pend_d;
    scatter_entry_t                  ent_q [NUM_PROD];
    acc_wr_t                         acc_q [NUM_BANKS];
    acc_wr_t                         win   [NUM_BANKS];
    logic [NUM_PROD-1:0][BANK_W-1:0] ent_bank;
    logic [NUM_PROD-1:0]             gnt   [NUM_BANKS];
    logic [NUM_PROD-1:0]             gnt_any;
    logic                            all_granted;
    logic                            capture;

    always_comb begin
        for (int p = 0; p < NUM_PROD; p++) begin
            ent_bank[p] = ent_q[p].bank;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        bank_priority_grant #(.BANK_ID(b)) u_grant (
            .pending (pend_q),
            .bank    (ent_bank),
            .grant   (gnt[b])
        );
    end

    // Grants are one-hot per bank, so OR-ing the masked entries acts as the mux.
    always_comb begin
        gnt_any = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            gnt_any = gnt_any | gnt[b];
            win[b]  = '0;
            win[b].en = |gnt[b];
            for (int p = 0; p < NUM_PROD; p++) begin
                if (gnt[b][p]) begin
                    win[b].addr = win[b].addr | ent_q[p].addr;
                    win[b].data = win[b].data | ent_q[p].data;
                end
            end
        end
    end

    assign all_granted = ((pend_q & ~gnt_any) == '0);

    // A new group may only land once the current one is fully granted this cycle,
    // so pending is never split between two groups.
    always_comb begin
        up.in_ready = 1'b0;
        if (!acc_stall && !flush) begin
            case (state_q)
                ST_IDLE:           up.in_ready = 1'b1;
                ST_ISSUE, ST_DRAIN: up.in_ready = all_granted;
                default:           up.in_ready = 1'b0;
            endcase
        end
    end

    assign capture = (|up.in_valid) && up.in_ready;

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else if (!acc_stall) begin
            case (state_q)
                ST_IDLE: begin
                    if (capture) state_d = ST_ISSUE;
                end
                ST_ISSUE, ST_DRAIN: begin
                    if (all_granted) state_d = capture ? ST_ISSUE : ST_IDLE;
                    else             state_d = ST_DRAIN;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        pend_d = pend_q;
        if (flush) begin
            pend_d = '0;
        end else if (!acc_stall) begin
            pend_d = pend_q & ~gnt_any;
            if (capture) pend_d = up.in_valid;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            pend_q          <= '0;
            conflict_cycles <= '0;
            for (int p = 0; p < NUM_PROD; p++) begin
                ent_q[p] <= '0;
            end
            for (int b = 0; b < NUM_BANKS; b++) begin
                acc_q[b] <= '0;
            end
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            if (!flush && !acc_stall && state_q == ST_DRAIN && conflict_cycles != 16'hFFFF) begin
                conflict_cycles <= conflict_cycles + 16'd1;
            end
            if (capture) begin
                for (int p = 0; p < NUM_PROD; p++) begin
                    ent_q[p] <= map_entry(up.in_k[p], up.in_row[p], up.in_col[p],
                                          out_side_length, up.in_data[p]);
                end
            end
            // Address/data only move on a real grant; a stall or flush just drops the strobe.
            for (int b = 0; b < NUM_BANKS; b++) begin
                acc_q[b].en <= 1'b0;
                if (!flush && !acc_stall && win[b].en) begin
                    acc_q[b] <= win[b];
                end
            end
        end
    end

    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            acc_wr_en[b]   = acc_q[b].en;
            acc_wr_addr[b] = acc_q[b].addr;
            acc_wr_data[b] = acc_q[b].data;
        end
    end

    assign busy = (state_q != ST_IDLE);

endmodule

// File: doc/product_scatter_arbiter.md
Name: product_scatter_arbiter

Overview:
- Sits directly downstream of the coordinate computation stage, which produces one valid-masked group of `I*`F products per cycle.
- Captures each group together with its multiplier products and maps every valid product's (k, row, col) to an accumulator bank and address.
- Issues at most one write per bank per cycle; bank conflicts are serialised across cycles while upstream is held off via in_ready.

Parameters:
- NUM_PROD, `I*`F (16): products per input group.
- NUM_BANKS, 32: accumulator banks; must be a power of two.
- DATA_W, 24: product and accumulator data width.
- COORD_W, $clog2(`max_size_output)+1: width of the row/col fields.
- K_W, $clog2(`max_num_K)+1: width of the k field.
- ADDR_W, 10: per-bank address width.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: reset, asynchronous, active-low.
- flush, input, 1: synchronous flush; drops all pending products.
- out_side_length, input, COORD_W: output tile side length; static while busy.
- in_valid, input, NUM_PROD: per-product valid mask (the coordinate stage valid).
- in_row, input, NUM_PROD x COORD_W: 1-based output row.
- in_col, input, NUM_PROD x COORD_W: 1-based output column.
- in_k, input, NUM_PROD x K_W: output channel.
- in_data, input, NUM_PROD x DATA_W: product values.
- in_ready, output, 1: group accepted this cycle when asserted together with |in_valid.
- acc_stall, input, 1: accumulator back-pressure; freezes all state.
- acc_wr_en, output, NUM_BANKS: per-bank write strobe.
- acc_wr_addr, output, NUM_BANKS x ADDR_W: per-bank address.
- acc_wr_data, output, NUM_BANKS x DATA_W: per-bank data.
- busy, output, 1: pending mask non-zero.
- conflict_cycles, output, 16: saturating count of cycles spent in DRAIN.

Behaviour:
- Reset values: all registers 0; state IDLE; acc_wr_en=0; conflict_cycles=0; in_ready=1 once reset deasserts.
- Address map, computed at capture per product: lin = k*side*side + (row-1)*side + (col-1), with side = out_side_length.
  - bank = lin[log2(NUM_BANKS)-1:0]; bank_addr = lin >> log2(NUM_BANKS), truncated to ADDR_W.
  - Intermediate width must be sufficient for the full product; there is no wrap before truncation.
- Capture: when |in_valid & in_ready & ~acc_stall, register in_valid as pending[], plus bank, bank_addr and data per product. All-zero in_valid is ignored and does not count as a capture.
- Grant (combinational from registered pending):
  - For each bank, grant the lowest-index pending product mapped to it.
  - Registered outputs: acc_wr_en/addr/data take the granted values on the next edge unless acc_stall.
  - Granted products clear from pending on the same edge.
- Latency: capture edge to the write strobe is 1 cycle for a conflict-free group.
- FSM:
  - IDLE: pending==0. in_ready=1. Capture goes to ISSUE.
  - ISSUE: first grant cycle of the group.
    - If the grant covers all of pending: in_ready=1 (back-to-back capture allowed); a new capture stays in ISSUE, otherwise go to IDLE.
    - Else: in_ready=0; go to DRAIN.
  - DRAIN: same grant rule. in_ready=1 only in the cycle the remaining pending is fully granted. conflict_cycles increments each DRAIN cycle, saturating at 0xFFFF.
- Same-address duplicates (same bank and address) serialise in index order; merging is never performed.
- acc_stall=1:
  - pending, state and counters hold; acc_wr_en=0 the following cycle; in_ready=0.
  - Output registers hold their address and data, but the strobe is dropped.
- flush (synchronous) has priority over capture: pending cleared, state to IDLE, acc_wr_en=0 next cycle; conflict_cycles is preserved.
- Reset mid-DRAIN: everything clears asynchronously; no further writes.
- busy = (state != IDLE).

Decomposition:
- Shared package: NUM_BANKS, DATA_W, ADDR_W; an acc_wr_t struct {en, addr, data}; a scatter_entry_t struct {bank, addr, data}.
- One sub-module: bank_priority_grant. Per bank it is a lowest-index priority encoder over (pending & bank_match), producing a one-hot grant vector. It is instantiated NUM_BANKS times via generate.

Test Plan:
- 16 products, k=0, side=8, rows 1..2, cols 1..8 (lin 0..15, all distinct banks) → in_ready stays 1. One cycle after capture: acc_wr_en=0x0000FFFF and acc_wr_addr all 0. conflict_cycles=0.
- 4 valid products with lin 0, 32, 64, 96 (all bank 0) → bank-0 writes on 4 consecutive cycles, addr 0,1,2,3 in index order. in_ready=0 for 3 cycles. conflict_cycles=3.
- Back-to-back conflict-free groups on consecutive cycles → a write every cycle; in_ready never drops.
- acc_stall asserted during DRAIN of the bank-0 case for 2 cycles → no strobes during the stall. Remaining addresses are issued after release, with none lost or duplicated.
- Duplicate: two products with k=1, row=3, col=5, side=8 (lin=84, bank 20, addr 2) → two bank-20 writes at addr 2 on consecutive cycles, data in index order.
- Async reset (rst low) mid-DRAIN, and separately flush mid-DRAIN → pending cleared and no further writes. in_ready=1 after rst rises. conflict_cycles is 0 after reset and unchanged after flush.
